mbr_unit: RTL and testbench
===========================

Name: mbr_unit

Overview:
- Memory Buffer Register of the 16-bit accumulator CPU datapath, between the memory data bus and the ACC/ALU side.
- Loads from memory read data (C3) or from the accumulator (C12).
- Drives a separately registered write-data copy toward memory on C11.
- Control strobes C3/C11/C12 are bits 3/11/12 of the control unit's Control_Signals word.

Parameters:
- WIDTH, 16, data width of MBR, ACC_in and memory buses.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- C3  input  1  load MBR from MBR_in_memory (MBR <- memory).
- C11  input  1  load memory write register from MBR (memory <- MBR).
- C12  input  1  load MBR from ACC_in (MBR <- ACC).
- ACC_in  input  WIDTH  accumulator value.
- MBR_in_memory  input  WIDTH  memory read data.
- MBR_out  output  WIDTH  current MBR contents, to datapath.
- MBR_out_memory  output  WIDTH  registered write data, to memory.

Behaviour:
- Two registers: mbr (drives MBR_out) and mem_wr (drives MBR_out_memory). Both outputs come directly from flops, no combinational path from inputs.
- Reset: rst_n low clears mbr and mem_wr to 0 immediately, independent of clk. Reset mid-operation discards any pending load.
- Rising edge, mbr update:
  - C3=1: mbr <= MBR_in_memory.
  - else C12=1: mbr <= ACC_in.
  - else hold.
  - C3 and C12 both high: C3 wins.
- Rising edge, mem_wr update:
  - C11=1: mem_wr <= mbr value present before this edge.
  - else hold.
- Simultaneous C3 (or C12) and C11 on one edge: mem_wr takes the old mbr and mbr takes the new source. Same-edge read-and-write-back never forwards the new value.
- Latency: one clock edge from strobe to visible output; strobes are level-sampled, one load per edge while held.
- Hold: MBR_out_memory keeps its last value indefinitely between C11 strobes.
- No handshake and no stall; the control unit guarantees strobe timing.
- Width: straight WIDTH-bit copies, no extension or truncation.

Optional Feature:
- Macro MBR_CONFLICT_EN.
- Defined:
  - Extra output port conflict (1 bit).
  - Registered flag, set on any rising edge where C3 and C12 are both high.
  - Cleared on the next edge where they are not both high; async-reset to 0.
  - The C3-priority data behaviour is unchanged.
- Undefined: port absent, no extra logic, behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg:
  - Constant DATA_W=16.
  - Control-bit index constants CTRL_MBR_FROM_MEM=3, CTRL_MEM_FROM_MBR=11, CTRL_MBR_FROM_ACC=12.
  - Reset value constant MBR_RST=0.
- One natural sub-module: en_reg, a WIDTH-wide enable-loaded flop with async active-low clear.
  - Instantiated twice: mbr with mux input, mem_wr with enable C11.

Test Plan:
- Reset: rst_n=0 for 20 ns, ACC_in=1234, MBR_in_memory=5678 -> MBR_out=0000, MBR_out_memory=0000; async clear verified mid-cycle.
- C3 one cycle, MBR_in_memory=5678 -> MBR_out=5678 after the edge; MBR_out_memory stays 0000.
- C12 one cycle, ACC_in=1234 -> MBR_out=1234; MBR_out_memory stays 0000.
- C11 one cycle -> MBR_out_memory=1234; MBR_out stays 1234; value held after C11 drops.
- C3+C11 same cycle, MBR_in_memory=9ABC -> MBR_out=9ABC and MBR_out_memory=1234 (old value). Following C11 alone -> MBR_out_memory=9ABC.
- C3+C12 same cycle, MBR_in_memory=DEF0, ACC_in=1234 -> MBR_out=DEF0. With MBR_CONFLICT_EN, conflict=1 for that cycle, then 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants for the 16-bit accumulator CPU.
`default_nettype none
package cpu_pkg;
  localparam int DATA_W = 16;

  // Bit positions of the MBR strobes within the control unit's Control_Signals word
  localparam int CTRL_MBR_FROM_MEM = 3;
  localparam int CTRL_MEM_FROM_MBR = 11;
  localparam int CTRL_MBR_FROM_ACC = 12;

  localparam logic [DATA_W-1:0] MBR_RST = '0;
endpackage
`default_nettype wire

// File: rtl/mbr_unit_if.sv
// mbr_unit_if: strobes and data buses between the control/datapath side and the MBR.
`default_nettype none
interface mbr_unit_if #(
  parameter int WIDTH = 16
);
  logic             C3;
  logic             C11;
  logic             C12;
  logic [WIDTH-1:0] ACC_in;
  logic [WIDTH-1:0] MBR_in_memory;
  logic [WIDTH-1:0] MBR_out;
  logic [WIDTH-1:0] MBR_out_memory;

  modport master (
    output C3, C11, C12, ACC_in, MBR_in_memory,
    input  MBR_out, MBR_out_memory
  );

  modport slave (
    input  C3, C11, C12, ACC_in, MBR_in_memory,
    output MBR_out, MBR_out_memory
  );
endinterface
`default_nettype wire

// File: rtl/mbr_unit_en_reg.sv
// en_reg: WIDTH-wide register loaded when en is high, asynchronously cleared to RST_VAL.
`default_nettype none
module en_reg #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mbr_unit.sv
// mbr_unit: Memory Buffer Register with a separately registered memory write-data copy.
// Optional MBR_CONFLICT_EN adds a registered flag for C3/C12 asserted on the same edge.
`default_nettype none
module mbr_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  mbr_unit_if.slave  bus
`ifdef MBR_CONFLICT_EN
  ,
  output logic       conflict
`endif
);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(MBR_RST);

  logic             mbr_en;
  logic [WIDTH-1:0] mbr_d;
  logic [WIDTH-1:0] mbr_q;
  logic [WIDTH-1:0] mem_wr_q;

  // Memory load has priority over the accumulator load
  always_comb begin
    mbr_en = bus.C3 | bus.C12;
    mbr_d  = bus.C3 ? bus.MBR_in_memory : bus.ACC_in;
  end

  en_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_mbr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mbr_en),
    .d     (mbr_d),
    .q     (mbr_q)
  );

  // Fed from the mbr flop output, so a same-edge load never forwards into mem_wr
  en_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_mem_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.C11),
    .d     (mbr_q),
    .q     (mem_wr_q)
  );

  assign bus.MBR_out        = mbr_q;
  assign bus.MBR_out_memory = mem_wr_q;

`ifdef MBR_CONFLICT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else begin
      conflict <= bus.C3 & bus.C12;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mbr_unit.sv
// tb_mbr_unit: directed-vector self-checking bench for mbr_unit.
`default_nettype none
module tb_mbr_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [15:0] ctrl;

  mbr_unit_if #(.WIDTH(DATA_W)) bus ();

`ifdef MBR_CONFLICT_EN
  logic conflict;
`endif

  mbr_unit #(.WIDTH(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave)
`ifdef MBR_CONFLICT_EN
    ,
    .conflict (conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [15:0] c, input logic [15:0] acc, input logic [15:0] mem);
    ctrl              = c;
    bus.C3            = c[CTRL_MBR_FROM_MEM];
    bus.C11           = c[CTRL_MEM_FROM_MBR];
    bus.C12           = c[CTRL_MBR_FROM_ACC];
    bus.ACC_in        = acc;
    bus.MBR_in_memory = mem;
  endtask

  // Drive at the falling edge, then sample 1 ns after the following rising edge
  task automatic step(input logic [15:0] c, input logic [15:0] acc, input logic [15:0] mem);
    @(negedge clk);
    apply(c, acc, mem);
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] S_C3  = 16'h0008;
  localparam logic [15:0] S_C11 = 16'h0800;
  localparam logic [15:0] S_C12 = 16'h1000;
  localparam logic [15:0] S_NONE = 16'h0000;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    apply(S_NONE, 16'h1234, 16'h5678);
    #20;
    chk("rst_mbr", 32'(bus.MBR_out), 32'h0000);
    chk("rst_memwr", 32'(bus.MBR_out_memory), 32'h0000);
`ifdef MBR_CONFLICT_EN
    chk("rst_conflict", 32'(conflict), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    step(S_C3, 16'h1234, 16'h5678);
    chk("c3_mbr", 32'(bus.MBR_out), 32'h5678);
    chk("c3_memwr", 32'(bus.MBR_out_memory), 32'h0000);

    step(S_C12, 16'h1234, 16'h5678);
    chk("c12_mbr", 32'(bus.MBR_out), 32'h1234);
    chk("c12_memwr", 32'(bus.MBR_out_memory), 32'h0000);

    step(S_C11, 16'h0000, 16'h0000);
    chk("c11_memwr", 32'(bus.MBR_out_memory), 32'h1234);
    chk("c11_mbr", 32'(bus.MBR_out), 32'h1234);
    step(S_NONE, 16'hFFFF, 16'hFFFF);
    step(S_NONE, 16'hAAAA, 16'h5555);
    chk("hold_memwr", 32'(bus.MBR_out_memory), 32'h1234);
    chk("hold_mbr", 32'(bus.MBR_out), 32'h1234);

    step(S_C3 | S_C11, 16'h0000, 16'h9ABC);
    chk("c3c11_mbr", 32'(bus.MBR_out), 32'h9ABC);
    chk("c3c11_memwr_old", 32'(bus.MBR_out_memory), 32'h1234);
    step(S_C11, 16'h0000, 16'h0000);
    chk("c11_after_memwr", 32'(bus.MBR_out_memory), 32'h9ABC);

    step(S_C3 | S_C12, 16'h1234, 16'hDEF0);
    chk("c3c12_prio", 32'(bus.MBR_out), 32'hDEF0);
`ifdef MBR_CONFLICT_EN
    chk("conflict_set", 32'(conflict), 32'h1);
`endif
    step(S_NONE, 16'h1234, 16'hDEF0);
    chk("c3c12_hold", 32'(bus.MBR_out), 32'hDEF0);
`ifdef MBR_CONFLICT_EN
    chk("conflict_clr", 32'(conflict), 32'h0);
`endif

    // Held strobe loads once per edge
    step(S_C12, 16'h1111, 16'h0000);
    chk("c12_held_1", 32'(bus.MBR_out), 32'h1111);
    step(S_C12, 16'h2222, 16'h0000);
    chk("c12_held_2", 32'(bus.MBR_out), 32'h2222);
    step(S_C12 | S_C11, 16'h3030, 16'h0000);
    chk("c12c11_mbr", 32'(bus.MBR_out), 32'h3030);
    chk("c12c11_memwr_old", 32'(bus.MBR_out_memory), 32'h2222);

    // Async clear mid-cycle with a load pending
    @(negedge clk);
    apply(S_C3 | S_C11, 16'h0000, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mbr", 32'(bus.MBR_out), 32'h0000);
    chk("async_memwr", 32'(bus.MBR_out_memory), 32'h0000);
    @(posedge clk);
    #1;
    chk("rst_discard_mbr", 32'(bus.MBR_out), 32'h0000);
    chk("rst_discard_memwr", 32'(bus.MBR_out_memory), 32'h0000);
    @(negedge clk);
    apply(S_NONE, 16'h0000, 16'h3333);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_mbr", 32'(bus.MBR_out), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
